// File: rtl/event_encoder_8to3.sv
// Captures one-cycle event lines into a pending vector and presents them one at a time
// as a binary code behind a valid/ready output register.
module event_encoder_8to3 #(
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [7:0] in,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic       overflow
);

    logic [7:0] pending_q, pending_d;
    logic [2:0] out_code_q, out_code_d;
    logic       out_valid_q, out_valid_d;
    logic       overflow_q, overflow_d;
    logic [2:0] last_idx_q, last_idx_d;

    logic [2:0] scan_start;
    logic [2:0] cand;
    logic [2:0] sel_idx;
    logic       sel_found;
    logic       out_free;
    logic       load;
    logic [7:0] load_mask;

    // Scan only the registered pending vector; fixed priority always starts at index 0.
    always_comb begin
        scan_start = (ROUND_ROBIN != 0) ? last_idx_q + 3'd1 : 3'd0;
        sel_found  = 1'b0;
        sel_idx    = 3'd0;
        cand       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = scan_start + 3'(i);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        out_free  = !out_valid_q || out_ready;
        load      = out_free && sel_found;
        load_mask = load ? (8'b0000_0001 << sel_idx) : 8'h00;

        // A fresh event on the bit being loaded simply re-arms it without overflow.
        pending_d   = (pending_q & ~load_mask) | in;
        overflow_d  = |(in & pending_q & ~load_mask);
        out_code_d  = load ? sel_idx : out_code_q;
        out_valid_d = out_free ? sel_found : out_valid_q;
        last_idx_d  = load ? sel_idx : last_idx_q;

        if (clr) begin
            pending_d   = 8'h00;
            overflow_d  = 1'b0;
            out_code_d  = out_code_q;
            out_valid_d = 1'b0;
            last_idx_d  = 3'd7;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= 8'h00;
            out_code_q  <= 3'd0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            last_idx_q  <= 3'd7;
        end else begin
            pending_q   <= pending_d;
            out_code_q  <= out_code_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign pending   = pending_q;
    assign out_code  = out_code_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

`ifndef SYNTHESIS
    // A stalled output must not change under the consumer.
    hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !clr) |=> (out_valid && $stable(out_code)));

    flush_clears_state: assert property (@(posedge clk) disable iff (!rst_n)
        clr |=> (!out_valid && !overflow && pending == 8'h00));
`endif

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Directed bench for event_encoder_8to3: a fixed-priority and a round-robin instance, with
// accepted codes checked against a queue of expected codes filled by the stimulus.
module tb_event_encoder_8to3;

    typedef struct {
        int code;
        int cyc;   // expected acceptance cycle, -1 when only the order matters
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr0, clr1, rdy0, rdy1;
    logic [7:0] in0, in1;
    logic [2:0] code0, code1;
    logic       valid0, valid1, ovf0, ovf1;
    logic [7:0] pend0, pend1;

    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    event_encoder_8to3 #(.ROUND_ROBIN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr0), .in(in0), .out_code(code0),
        .out_valid(valid0), .out_ready(rdy0), .pending(pend0), .overflow(ovf0)
    );

    event_encoder_8to3 #(.ROUND_ROBIN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .in(in1), .out_code(code1),
        .out_valid(valid1), .out_ready(rdy1), .pending(pend1), .overflow(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input int code, input int c);
        exp_t e;
        e.code = code;
        e.cyc  = c;
        q0.push_back(e);
    endtask

    task automatic push1(input int code);
        exp_t e;
        e.code = code;
        e.cyc  = -1;
        q1.push_back(e);
    endtask

    // Monitors: a code is consumed when valid and ready meet at a clock edge outside flush.
    always @(negedge clk) begin
        if (rst_n && valid0 && rdy0 && !clr0) begin
            total++;
            if (q0.size() == 0) begin
                $display("FAIL sb0_unexpected: got code %0d at cycle %0d, expected none",
                         code0, cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (int'(code0) == e.code && (e.cyc < 0 || e.cyc == cyc)) passed++;
                else $display("FAIL sb0_code: got code %0d at cycle %0d, expected %0d at %0d",
                              code0, cyc, e.code, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid1 && rdy1 && !clr1) begin
            total++;
            if (q1.size() == 0) begin
                $display("FAIL sb1_unexpected: got code %0d, expected none", code1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (int'(code1) == e.code) passed++;
                else $display("FAIL sb1_code: got code %0d, expected %0d", code1, e.code);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        rdy0 = 1'b1; rdy1 = 1'b1;
        in0 = 8'h00; in1 = 8'h00;

        // Reset values, both before and after a clock edge under reset.
        #3;
        check("rst_pending", 32'(pend0), 32'h00);
        check("rst_valid", 32'(valid0), 32'h0);
        check("rst_code", 32'(code0), 32'h0);
        check("rst_overflow", 32'(ovf0), 32'h0);
        #9;
        check("rst_valid_after_edge", 32'(valid0), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // One-hot singles: each accepted two cycles after the cycle it was driven.
        for (int i = 0; i < 8; i++) begin
            in0 = 8'(1 << i);
            push0(i, cyc + 2);
            tick(1);
        end
        in0 = 8'h00;
        tick(4);

        // Arrival is visible in pending one cycle after sampling, not yet on the output.
        in0 = 8'h40;
        push0(6, cyc + 2);
        tick(1);
        in0 = 8'h00;
        check("arrive_pending", 32'(pend0), 32'h40);
        check("arrive_no_valid", 32'(valid0), 32'h0);
        tick(3);

        // Fixed-priority burst: 0,2,5,7 back to back, then idle.
        in0 = 8'hA5;
        push0(0, cyc + 2); push0(2, cyc + 3); push0(5, cyc + 4); push0(7, cyc + 5);
        tick(1);
        in0 = 8'h00;
        tick(5);
        check("burst_idle_valid", 32'(valid0), 32'h0);
        check("burst_idle_pending", 32'(pend0), 32'h00);

        // Backpressure: code 2 held while 3 waits in pending.
        rdy0 = 1'b0;
        in0 = 8'h0C;
        push0(2, -1); push0(3, -1);
        tick(1);
        in0 = 8'h00;
        tick(1);
        check("bp_pending", 32'(pend0), 32'h08);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("bp_hold", 32'({valid0, code0}), 32'b1010);
        end
        rdy0 = 1'b1;
        tick(4);
        check("bp_drained", 32'(valid0), 32'h0);

        // Overflow: a second sample of bit 3 while it is still pending.
        rdy0 = 1'b0;
        in0 = 8'h04;
        tick(1);
        in0 = 8'h00;
        tick(1);
        in0 = 8'h08;
        tick(1);
        check("ovf_first_sample", 32'(ovf0), 32'h0);
        check("ovf_first_pending", 32'(pend0), 32'h08);
        in0 = 8'h00;
        tick(1);
        in0 = 8'h08;
        tick(1);
        check("ovf_second_sample", 32'(ovf0), 32'h1);
        in0 = 8'h00;
        tick(1);
        check("ovf_pulse_ends", 32'(ovf0), 32'h0);
        check("ovf_pending_kept", 32'(pend0), 32'h08);
        // Same-edge reload: bit 3 is loaded while a new bit-3 event arrives.
        push0(2, -1); push0(3, -1); push0(3, -1);
        rdy0 = 1'b1;
        in0 = 8'h08;
        tick(1);
        check("reload_no_ovf", 32'(ovf0), 32'h0);
        check("reload_pending", 32'(pend0), 32'h08);
        check("reload_code", 32'(code0), 32'h3);
        in0 = 8'h00;
        tick(3);
        check("idle_code_holds", 32'({valid0, code0}), 32'b0011);

        // Round-robin: held 0x11 alternates 0,4 starting from index 0.
        in1 = 8'h11;
        for (int k = 0; k < 7; k++) push1((k % 2 == 0) ? 0 : 4);
        tick(2);
        check("rr_overflow", 32'(ovf1), 32'h1);
        tick(4);
        in1 = 8'h00;
        tick(4);
        check("rr_idle", 32'(valid1), 32'h0);
        // Last load was 0, so 7 is found before 0 comes round again.
        in1 = 8'h81;
        push1(7); push1(0);
        tick(1);
        in1 = 8'h00;
        tick(4);
        // Flush returns the round-robin pointer to 7, so 0 goes first.
        clr1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        in1 = 8'h81;
        push1(0); push1(7);
        tick(1);
        in1 = 8'h00;
        tick(4);

        // Asynchronous reset while code 0 is presented and 0xF0 pending.
        rdy0 = 1'b0;
        in0 = 8'hF1;
        tick(1);
        in0 = 8'h00;
        tick(1);
        check("pre_rst_pending", 32'(pend0), 32'hF0);
        check("pre_rst_valid", 32'(valid0), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 32'({pend0, code0, valid0, ovf0}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        rdy0 = 1'b1;
        tick(3);
        check("post_rst_no_replay", 32'({valid0, pend0}), 32'h0);

        // Flush while presenting: in and out_ready both ignored on the flush edge.
        rdy0 = 1'b0;
        in0 = 8'h06;
        tick(1);
        in0 = 8'h00;
        tick(1);
        check("pre_clr_out", 32'({valid0, code0}), 32'b1001);
        clr0 = 1'b1;
        in0 = 8'hFF;
        rdy0 = 1'b1;
        tick(1);
        check("clr_state", 32'({pend0, valid0, ovf0}), 32'h0);
        clr0 = 1'b0;
        in0 = 8'h00;
        tick(3);
        check("post_clr_idle", 32'({pend0, valid0}), 32'h0);

        tick(2);
        check("sb0_drained", 32'(q0.size()), 32'h0);
        check("sb1_drained", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/event_encoder_8to3.md
EVENT_ENCODER_8TO3 -- requirements
Module: event_encoder_8to3

Interface
REQ-001 The block SHALL have parameter ROUND_ROBIN, default 0, meaning 0 = fixed priority (lowest index first) and 1 = round-robin starting after the last loaded index.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port clr  input  1  synchronous flush of all pending and output state.
REQ-005 The block SHALL have port in  input  8  event lines, one per source; level sampled every cycle.
REQ-006 The block SHALL have port out_code  output  3  binary index of the presented event.
REQ-007 The block SHALL have port out_valid  output  1  out_code holds a valid event.
REQ-008 The block SHALL have port out_ready  input  1  consumer accepts out_code this cycle.
REQ-009 The block SHALL have port pending  output  8  events captured but not yet loaded to the output.
REQ-010 The block SHALL have port overflow  output  1  one-cycle pulse: event lost because its source bit was already pending.

Function
REQ-011 The block SHALL use clk as its only clock, with no combinational path from in to any output.
REQ-012 The block SHALL set pending[i] on any edge where in[i]=1.
REQ-013 The output register SHALL be free when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-014 When the output register is free and pending is non-zero, the block SHALL load the selected index into out_code, set out_valid and clear that pending bit on the same edge.
REQ-015 The block SHALL make a newly arrived in[i] visible in pending 1 cycle after sampling, and on out_valid no earlier than 2 cycles after sampling.
REQ-016 When a pending bit is cleared by a load and in[i]=1 on the same edge, pending[i] SHALL remain 1 (new event wins), with no overflow.
REQ-017 When in[i]=1 while pending[i]=1 and bit i is not loaded that edge, the block SHALL pulse overflow for one cycle, and pending[i] SHALL stay 1.
REQ-018 While out_valid=1 and out_ready=0, out_code and out_valid SHALL hold stable.
REQ-019 With out_ready held 1 and pending non-zero, the block SHALL load one code per cycle (full throughput).
REQ-020 When the output register is free and pending=0, the block SHALL drive out_valid to 0 on the next edge, and out_code SHALL hold its last value.
REQ-021 With ROUND_ROBIN=0, the block SHALL select the lowest set pending index.
REQ-022 With ROUND_ROBIN=1, the block SHALL select the first set index scanning upward from last_idx+1, wrapping 7->0; last_idx is a 3-bit register updated on every load.
REQ-023 With ROUND_ROBIN=1, the block SHALL reach last_idx itself only after all other indices are found clear.
REQ-024 The block SHALL select only from pending as registered, so events arriving this cycle are not eligible until the next cycle.
REQ-025 clr=1 SHALL force pending=0 and out_valid=0, set last_idx to 7 and suppress overflow, and SHALL ignore in and out_ready that cycle.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force pending=8'h00, out_code=3'd0, out_valid=0, overflow=0 and last_idx=3'd7, independent of clk.
REQ-027 After rst_n deasserts, the block SHALL sample in from the first following rising edge of clk.
REQ-028 When reset asserts mid-handshake, the block SHALL discard the presented code, and the code SHALL NOT reappear after reset.

Verification
REQ-029 Single events: in=8'h01..8'h80 one-hot, one cycle each, out_ready=1 -> out_code 0..7 in order, each valid exactly one cycle, 2 cycles after in.
REQ-030 Fixed priority burst: ROUND_ROBIN=0, in=8'hA5 for one cycle, out_ready=1 -> out_code sequence 0,2,5,7 on consecutive cycles, then out_valid=0, pending=0.
REQ-031 Round-robin: ROUND_ROBIN=1, hold in=8'h11 for 6 cycles with out_ready=1 -> codes alternate 0,4,0,4...
REQ-032 Backpressure: in=8'h0C once, out_ready=0 for 5 cycles -> out_code=2 held, pending=8'h08; then out_ready=1 -> 2 accepted, then 3.
REQ-033 Overflow: out_ready=0 with code 2 held, in=8'h08 on two separate cycles -> second sample pulses overflow; the same-edge reload case raises no overflow.
REQ-034 Reset/clr: rst_n low with out_valid=1 and pending=8'hF0 -> all outputs 0 immediately; repeat with clr=1 and in=8'hFF -> pending=0, out_valid=0 next edge.
